// File: rtl/stall_mem_resp.sv
// stall_mem_resp: fixed-latency 16-bit word store with a Stall/Done request handshake.
// Define STALL_MEM_ALIGN_CHECK_EN to flag and suppress accesses to odd byte addresses.
module stall_mem_resp #(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err
);

  localparam int         WORDS    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   op_wr_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [15:0]            data_q;
  logic                   mis_q;
  logic [15:0]            mem [WORDS];

  logic                   accept;
  logic                   req_mis;
  logic                   busy_last;
  logic                   enter_done;
  logic                   acc_wr;
  logic                   acc_mis;
  logic [ADDR_BITS-1:0]   acc_idx;
  logic [15:0]            acc_data;
  logic                   unused_addr;

  // Bits above the word index are deliberately ignored.
  assign unused_addr = ^Addr;

`ifdef STALL_MEM_ALIGN_CHECK_EN
  assign req_mis = Addr[0];
`else
  assign req_mis = 1'b0;
`endif

  assign accept     = (state != BUSY) && (Rd || Wr);
  assign busy_last  = (state == BUSY) && (cnt == 4'd1);
  assign enter_done = busy_last || (accept && (LATENCY == 1));
  assign Stall      = (state == BUSY);

  // The access happens on the edge entering DONE: from BUSY it uses the captured
  // request, with LATENCY=1 it uses the request being accepted on that same edge.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    acc_wr   = Wr;
    acc_idx  = Addr[ADDR_BITS:1];
    acc_data = DataIn;
    acc_mis  = req_mis;
    if (busy_last) begin
      acc_wr   = op_wr_q;
      acc_idx  = idx_q;
      acc_data = data_q;
      acc_mis  = mis_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      Done    <= 1'b0;
      err     <= 1'b0;
      DataOut <= 16'h0000;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= 16'h0000;
      mis_q   <= 1'b0;
    end else begin
      Done <= enter_done;
      err  <= enter_done && acc_mis;
      if (enter_done && !acc_wr && !acc_mis) begin
        DataOut <= mem[acc_idx];
      end

      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_wr_q <= Wr;
            idx_q   <= Addr[ADDR_BITS:1];
            data_q  <= DataIn;
            mis_q   <= req_mis;
            cnt     <= CNT_LOAD;
            state   <= (LATENCY == 1) ? DONE : BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (busy_last) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the storage is cleared by reset, so it is built from flops rather than a RAM macro without reset.
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= 16'h0000;
      end
    end else if (enter_done && acc_wr && !acc_mis) begin
      mem[acc_idx] <= acc_data;
    end
  end

endmodule

// File: tb/tb_stall_mem_resp.sv
// Self-checking bench for stall_mem_resp: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a timestamp-based model.
module tb_stall_mem_resp;

  localparam int LAT = 2;
  localparam int AB  = 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
`ifdef STALL_MEM_ALIGN_CHECK_EN
  localparam logic ALIGN = 1'b1;
`else
  localparam logic ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        Rd;
  logic        Wr;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  stall_mem_resp #(.LATENCY(LAT), .ADDR_BITS(AB)) dut (
    .clk    (clk),
    .rst    (rst),
    .Rd     (Rd),
    .Wr     (Wr),
    .Addr   (Addr),
    .DataIn (DataIn),
    .DataOut(DataOut),
    .Done   (Done),
    .Stall  (Stall),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        done;
    logic        stall;
    logic [15:0] dout;
    logic        err;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t v(input logic r, input logic rd, input logic wr,
                             input logic [15:0] a, input logic [15:0] d,
                             input logic dn, input logic st,
                             input logic [15:0] q, input logic e);
    vec_t t;
    t.rst = r; t.rd = rd; t.wr = wr; t.addr = a; t.din = d;
    t.done = dn; t.stall = st; t.dout = q; t.err = e;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic put(input logic r, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [15:0] d);
    rst = r; Rd = rd; Wr = wr; Addr = a; DataIn = d;
  endtask

  // Advance past one rising edge; outputs are sampled 1ns after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic dn, input logic st,
                            input logic [15:0] q, input logic e);
    check({tag, " Done"},    16'(Done),  16'(dn));
    check({tag, " Stall"},   16'(Stall), 16'(st));
    check({tag, " DataOut"}, DataOut,    q);
    check({tag, " err"},     16'(err),   16'(e));
  endtask

  // Reference model: a request accepted at edge e completes at edge e+LAT-1;
  // the design is busy strictly before that edge and free from it onwards.
  logic [15:0] ref_mem [256];
  int          done_edge;
  logic        p_wr;
  logic        p_mis;
  int          p_idx;
  logic [15:0] p_data;
  logic [15:0] ref_q;
  logic        ref_err;

  task automatic model_edge(input int e);
    if (rst) begin
      foreach (ref_mem[i]) ref_mem[i] = 16'h0000;
      done_edge = -100;
      ref_q     = 16'h0000;
      ref_err   = 1'b0;
      return;
    end
    if (done_edge <= e - 1 && (Rd || Wr)) begin
      done_edge = e + LAT - 1;
      p_wr      = Wr;
      p_idx     = (int'(Addr) / 2) % 256;
      p_data    = DataIn;
      p_mis     = ALIGN && Addr[0];
    end
    ref_err = 1'b0;
    if (e == done_edge) begin
      if (p_mis)     ref_err = 1'b1;
      else if (p_wr) ref_mem[p_idx] = p_data;
      else           ref_q = ref_mem[p_idx];
    end
  endtask

  initial begin
    int accepts;
    put(H, L, L, 16'h0000, 16'h0000);

    vecs[0]  = v(H, L, L, 16'h0000, 16'h0000, L, L, 16'h0000, L);
    vecs[1]  = v(L, L, H, 16'h0010, 16'hBEEF, L, H, 16'h0000, L);
    vecs[2]  = v(L, L, L, 16'h0000, 16'h0000, H, L, 16'h0000, L);
    vecs[3]  = v(L, H, L, 16'h0010, 16'h0000, L, H, 16'h0000, L);
    vecs[4]  = v(L, L, L, 16'h0000, 16'h0000, H, L, 16'hBEEF, L);
    vecs[5]  = v(L, L, L, 16'h0000, 16'h0000, L, L, 16'hBEEF, L);
    vecs[6]  = v(L, L, H, 16'h0002, 16'h1234, L, H, 16'hBEEF, L);
    vecs[7]  = v(L, L, L, 16'h0000, 16'h0000, H, L, 16'hBEEF, L);
    vecs[8]  = v(L, H, L, 16'h0002, 16'h0000, L, H, 16'hBEEF, L);
    vecs[9]  = v(L, L, L, 16'h0000, 16'h0000, H, L, 16'h1234, L);
    vecs[10] = v(L, L, L, 16'h0000, 16'h0000, L, L, 16'h1234, L);
    vecs[11] = v(L, H, H, 16'h0200, 16'h7777, L, H, 16'h1234, L);
    vecs[12] = v(L, L, L, 16'h0000, 16'h0000, H, L, 16'h1234, L);
    vecs[13] = v(L, H, L, 16'h0000, 16'h0000, L, H, 16'h1234, L);
    vecs[14] = v(L, L, L, 16'h0000, 16'h0000, H, L, 16'h7777, L);
    vecs[15] = v(L, L, H, 16'h0009, 16'h5555, L, H, 16'h7777, L);
    vecs[16] = v(L, L, L, 16'h0000, 16'h0000, H, L, 16'h7777, ALIGN);
    vecs[17] = v(L, H, L, 16'h0008, 16'h0000, L, H, 16'h7777, L);
    vecs[18] = v(L, L, L, 16'h0000, 16'h0000, H, L, ALIGN ? 16'h7777 : 16'h5555, L);

    foreach (vecs[i]) begin
      put(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
      tick();
      expect_out($sformatf("row%0d", i), vecs[i].done, vecs[i].stall, vecs[i].dout, vecs[i].err);
    end

    // Rd held continuously while the address flips between accept slots and BUSY.
    put(L, L, L, 16'h0000, 16'h0000); tick();
    put(L, L, H, 16'h0004, 16'h4444); tick();
    put(L, L, L, 16'h0000, 16'h0000); tick(); tick();
    put(L, L, H, 16'h000C, 16'hCCCC); tick();
    put(L, L, L, 16'h0000, 16'h0000); tick(); tick();
    accepts = 0;
    for (int k = 0; k < 6; k++) begin
      put(L, H, L, (k % 2 == 0) ? 16'h0004 : 16'h000C, 16'h0000);
      tick();
      if (Stall) accepts++;
      check($sformatf("hold%0d Stall", k), 16'(Stall), 16'(k % 2 == 0));
      check($sformatf("hold%0d Done", k),  16'(Done),  16'(k % 2 == 1));
      if (k % 2 == 1) check($sformatf("hold%0d DataOut", k), DataOut, 16'h4444);
    end
    check("hold accepts", 16'(accepts), 16'd3);

    // Reset during BUSY aborts the write; a read on the first free edge sees zero.
    put(L, L, L, 16'h0000, 16'h0000); tick(); tick();
    put(L, L, H, 16'h0006, 16'hAAAA); tick();
    check("abort busy Stall", 16'(Stall), 16'd1);
    put(H, L, L, 16'h0000, 16'h0000); tick();
    expect_out("abort rst", L, L, 16'h0000, L);
    put(L, H, L, 16'h0006, 16'h0000); tick();
    expect_out("abort rd accept", L, H, 16'h0000, L);
    put(L, L, L, 16'h0000, 16'h0000); tick();
    expect_out("abort rd done", H, L, 16'h0000, L);

    // Random traffic against the reference model.
    for (int e = 0; e < 1500; e++) begin
      int op;
      logic [15:0] a;
      op = $urandom_range(0, 3);
      a  = 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 3)) << 9);
      put((e == 0) || ($urandom_range(0, 59) == 0), op[0], op[1], a, 16'($urandom));
      tick();
      model_edge(e);
      expect_out($sformatf("rnd%0d", e), (e == done_edge), (e < done_edge), ref_q, ref_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
